// File: rtl/ssp_rx_deframer.sv
// SSP receive deframer: generates ssp_clk/ssp_frame as master, shifts in ssp_dout MSB-first
// and queues completed words in a show-ahead FIFO with a valid/ready interface.
module ssp_rx_deframer #(
   parameter int CLK_DIV    = 8,
   parameter int WORD_BITS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          ck_1356meg,
   input  logic                          reset,
   input  logic                          en,
   input  logic                          ssp_dout,
   output logic                          ssp_clk,
   output logic                          ssp_frame,
   output logic [WORD_BITS-1:0]          rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          busy
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int BIT_W = $clog2(WORD_BITS);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, FRAME = 2'd1, SHIFT = 2'd2} state_t;

   state_t                 state_q, state_d;
   logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [WORD_BITS-1:0]   sr_q, sr_d;
   logic                   ssp_clk_q, ssp_clk_d;
   logic                   ssp_frame_q, ssp_frame_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]       level_q, level_d;
   logic [WORD_BITS-1:0]   mem_q [FIFO_DEPTH];
   logic                   sample, push, pop;

   assign rx_valid   = (level_q != '0);
   assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : '0;
   assign fifo_level = level_q;
   assign busy       = (state_q != IDLE);
   assign ssp_clk    = ssp_clk_q;
   assign ssp_frame  = ssp_frame_q;

   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      bit_cnt_d = bit_cnt_q;
      sr_d      = sr_q;
      push      = 1'b0;
      pop       = rx_valid && rx_ready;
      sample    = (div_cnt_q == DIV_LAST);

      case (state_q)
         IDLE: begin
            div_cnt_d = '0;
            if (en && (level_q < LVL_FULL)) state_d = FRAME;
         end
         FRAME: begin
            div_cnt_d = sample ? '0 : div_cnt_q + DIV_W'(1);
            if (sample) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
            end
         end
         SHIFT: begin
            div_cnt_d = sample ? '0 : div_cnt_q + DIV_W'(1);
            if (sample) begin
               sr_d = {sr_q[WORD_BITS-2:0], ssp_dout};
               if (bit_cnt_q == BIT_LAST) push = 1'b1;
               else bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      // Chain straight into the next frame only when a slot is guaranteed for it
      if (push) begin
         div_cnt_d = '0;
         state_d   = (en && (level_d < LVL_FULL)) ? FRAME : IDLE;
      end

      ssp_clk_d   = (state_d != IDLE) && (div_cnt_d >= DIV_HALF);
      ssp_frame_d = (state_d == FRAME);
   end

   always_ff @(posedge ck_1356meg) begin
      if (reset) begin
         state_q     <= IDLE;
         div_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         ssp_clk_q   <= 1'b0;
         ssp_frame_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         ssp_clk_q   <= ssp_clk_d;
         ssp_frame_q <= ssp_frame_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
      end
      // Data path carries no reset; rx_data is masked by rx_valid instead
      sr_q <= sr_d;
      if (push && !reset) mem_q[wr_ptr_q] <= sr_d;
   end

endmodule

// File: tb/tb_ssp_rx_deframer.sv
// Directed bench for ssp_rx_deframer with an ARM-side serial model feeding ssp_dout.
module tb_ssp_rx_deframer;

   logic       ck_1356meg = 1'b0;
   logic       reset;
   logic       en;
   logic       ssp_dout = 1'b0;
   logic       ssp_clk;
   logic       ssp_frame;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [2:0] fifo_level;
   logic       busy;

   int checks = 0;
   int errors = 0;
   logic [7:0] tx_q[$];

   ssp_rx_deframer #(.CLK_DIV(8), .WORD_BITS(8), .FIFO_DEPTH(4)) dut (
      .ck_1356meg (ck_1356meg),
      .reset      (reset),
      .en         (en),
      .ssp_dout   (ssp_dout),
      .ssp_clk    (ssp_clk),
      .ssp_frame  (ssp_frame),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .fifo_level (fifo_level),
      .busy       (busy)
   );

   always #5 ck_1356meg = ~ck_1356meg;

   // ARM side: after each frame, present one bit per ssp_clk rising edge, MSB first
   always begin : arm_bfm
      logic [7:0] w;
      @(negedge ssp_frame);
      w = (tx_q.size() > 0) ? tx_q.pop_front() : 8'h00;
      for (int i = 7; i >= 0; i--) begin
         @(posedge ssp_clk);
         if (ssp_frame) break;
         #1 ssp_dout = w[i];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge ck_1356meg);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_frame(input string tag);
      for (int i = 0; i < 300 && ssp_frame !== 1'b1; i++) tick(1);
      chk(tag, ssp_frame, 1);
   endtask

   task automatic drain(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                        input logic [7:0] w2, input logic [7:0] w3);
      logic [7:0] exp [4];
      exp = '{w0, w1, w2, w3};
      rx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk(tag, rx_data, exp[i]);
         tick(1);
      end
      rx_ready = 1'b0;
      chk({tag, "_empty"}, fifo_level, 0);
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; rx_ready = 1'b0;
      tick(3);
      chk("rst_clk", ssp_clk, 0);
      chk("rst_frame", ssp_frame, 0);
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      tick(1);

      // Single word 0xA5
      rx_ready = 1'b1;
      tx_q.push_back(8'hA5);
      en = 1'b1;
      wait_frame("t1_frame_start");
      en = 1'b0;
      chk("t1_busy", busy, 1);
      chk("t1_clk_lo", ssp_clk, 0);
      tick(4);
      chk("t1_clk_hi", ssp_clk, 1);
      tick(3);
      chk("t1_frame_last", ssp_frame, 1);
      tick(1);
      chk("t1_frame_drop", ssp_frame, 0);
      chk("t1_clk_bit0", ssp_clk, 0);
      chk("t1_busy_shift", busy, 1);
      tick(63);
      chk("t1_valid_early", rx_valid, 0);
      tick(1);
      chk("t1_valid", rx_valid, 1);
      chk("t1_data", rx_data, 8'hA5);
      chk("t1_busy_done", busy, 0);
      tick(1);
      chk("t1_valid_pulse", rx_valid, 0);
      chk("t1_level", fifo_level, 0);

      // Back-to-back words
      tx_q.push_back(8'h3C); tx_q.push_back(8'hC3); tx_q.push_back(8'hFF);
      en = 1'b1;
      wait_frame("t2_frame_start");
      tick(72);
      chk("t2_frame2", ssp_frame, 1);
      chk("t2_data0", rx_data, 8'h3C);
      chk("t2_level0", fifo_level, 1);
      tick(72);
      chk("t2_frame3", ssp_frame, 1);
      chk("t2_data1", rx_data, 8'hC3);
      chk("t2_level1", fifo_level, 1);
      en = 1'b0;
      tick(72);
      chk("t2_data2", rx_data, 8'hFF);
      chk("t2_valid2", rx_valid, 1);
      chk("t2_busy", busy, 0);
      chk("t2_frame_end", ssp_frame, 0);
      tick(1);
      chk("t2_level_end", fifo_level, 0);

      // Backpressure: FIFO fills, ssp_clk stalls
      rx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) tx_q.push_back(8'(i));
      en = 1'b1;
      wait_frame("t3_frame_start");
      tick(288);
      chk("t3_level_full", fifo_level, 4);
      chk("t3_busy_stall", busy, 0);
      chk("t3_clk_stall", ssp_clk, 0);
      chk("t3_head", rx_data, 8'h01);
      tick(3);
      chk("t3_clk_held", ssp_clk, 0);
      chk("t3_busy_held", busy, 0);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      chk("t3_level_pop", fifo_level, 3);
      chk("t3_head_adv", rx_data, 8'h02);
      chk("t3_busy_pop", busy, 0);
      tick(1);
      chk("t3_restart_busy", busy, 1);
      chk("t3_restart_frame", ssp_frame, 1);
      en = 1'b0;
      tick(72);
      chk("t3_level_refull", fifo_level, 4);
      chk("t3_busy_end", busy, 0);
      drain("t3_order", 8'h02, 8'h03, 8'h04, 8'h05);

      // Pop coinciding with push at level 3
      tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
      tx_q.push_back(8'h44); tx_q.push_back(8'h55);
      en = 1'b1;
      wait_frame("t6_frame_start");
      tick(216);
      chk("t6_level3", fifo_level, 3);
      chk("t6_frame4", ssp_frame, 1);
      tick(71);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      chk("t6_level_same", fifo_level, 3);
      chk("t6_frame_next", ssp_frame, 1);
      chk("t6_busy", busy, 1);
      chk("t6_head", rx_data, 8'h22);
      en = 1'b0;
      tick(72);
      chk("t6_level_full", fifo_level, 4);
      chk("t6_busy_end", busy, 0);
      drain("t6_order", 8'h22, 8'h33, 8'h44, 8'h55);

      // en dropped mid-word: word still completes
      tx_q.push_back(8'h96);
      en = 1'b1;
      wait_frame("t4_frame_start");
      tick(35);
      en = 1'b0;
      tick(37);
      chk("t4_level", fifo_level, 1);
      chk("t4_data", rx_data, 8'h96);
      chk("t4_busy", busy, 0);
      tick(20);
      chk("t4_no_frame", ssp_frame, 0);
      chk("t4_idle", busy, 0);
      chk("t4_level_hold", fifo_level, 1);

      // Reset during bit 5, then a clean word
      tx_q.push_back(8'h77); tx_q.push_back(8'h5A);
      en = 1'b1;
      wait_frame("t5_frame_start");
      tick(53);
      chk("t5_clk_pre", ssp_clk, 1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("t5_clk", ssp_clk, 0);
      chk("t5_frame", ssp_frame, 0);
      chk("t5_valid", rx_valid, 0);
      chk("t5_level", fifo_level, 0);
      chk("t5_busy", busy, 0);
      wait_frame("t5_frame_restart");
      en = 1'b0;
      tick(72);
      chk("t5_valid_new", rx_valid, 1);
      chk("t5_data_new", rx_data, 8'h5A);
      chk("t5_level_new", fifo_level, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
